vectadd_engine: RTL

- Vector-add compute stage sitting directly upstream of the 2-bit software-status input PIO; its `status` output drives that PIO's `in_port`.
- On a software start command it reads A[i] and B[i] from two on-chip RAMs, writes C[i] = A[i] + B[i] to a third RAM for i = 0..len-1, then reports done.
- Software polls busy/done through the status PIO and issues start/clear through a control PIO.

---
 rtl/vectadd_pkg.sv | 17 +
 rtl/vectadd_engine_if.sv | 29 ++
 rtl/vectadd_engine_edge_det.sv | 24 ++
 rtl/vectadd_engine.sv | 123 ++++++++++++
 4 files changed

// File: rtl/vectadd_pkg.sv
// Shared types and bit positions for the vector-add engine and its
// control/status PIO interfaces.
package vectadd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int CTRL_START  = 0;
  localparam int CTRL_CLEAR  = 1;
  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;

endpackage

// File: rtl/vectadd_engine_if.sv
// Bundle of PIO and RAM-port signals between the vector-add engine
// (slave side) and the software PIOs plus the three on-chip RAMs (master side).
interface vectadd_engine_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);

  logic [1:0]        ctrl;
  logic [ADDR_W:0]   vec_len;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_rddata;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_rddata;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wrdata;
  logic              c_wren;
  logic [1:0]        status;

  modport slave (
    input  ctrl, vec_len, a_rddata, b_rddata,
    output a_addr, b_addr, c_addr, c_wrdata, c_wren, status
  );

  modport master (
    output ctrl, vec_len, a_rddata, b_rddata,
    input  a_addr, b_addr, c_addr, c_wrdata, c_wren, status
  );

endinterface

// File: rtl/vectadd_engine_edge_det.sv
// Rising-edge detector; the reset value of the history flop is programmable
// so a level already high when reset releases does not count as an edge.
module vectadd_edge_det #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic edge_o
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= RESET_VAL;
    end else begin
      level_q <= level_i;
    end
  end

  assign edge_o = level_i & ~level_q;

endmodule

// File: rtl/vectadd_engine.sv
// Vector-add engine: on a start edge streams C[i] = A[i] + B[i] for
// i = 0..len-1 at one element per cycle, then reports done to software.
module vectadd_engine
  import vectadd_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  vectadd_engine_if.slave bus
);

  localparam logic [ADDR_W:0] ONE = (ADDR_W + 1)'(1);

  logic start_edge;

  // History flop resets high so a start held through reset is not an edge.
  vectadd_edge_det #(
    .RESET_VAL(1'b1)
  ) u_start_det (
    .clk    (clk),
    .reset  (reset),
    .level_i(bus.ctrl[CTRL_START]),
    .edge_o (start_edge)
  );

  state_e            state_q,      state_d;
  logic [ADDR_W:0]   len_q,        len_d;
  logic [ADDR_W:0]   rd_idx_q,     rd_idx_d;
  logic              pipe_valid_q, pipe_valid_d;
  logic [ADDR_W-1:0] pipe_idx_q,   pipe_idx_d;
  logic              c_wren_q,     c_wren_d;
  logic [ADDR_W-1:0] c_addr_q,     c_addr_d;
  logic [DATA_W-1:0] c_wrdata_q,   c_wrdata_d;
  logic [1:0]        status_q,     status_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      rd_idx_q     <= '0;
      pipe_valid_q <= 1'b0;
      pipe_idx_q   <= '0;
      c_wren_q     <= 1'b0;
      c_addr_q     <= '0;
      c_wrdata_q   <= '0;
      status_q     <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      rd_idx_q     <= rd_idx_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_idx_q   <= pipe_idx_d;
      c_wren_q     <= c_wren_d;
      c_addr_q     <= c_addr_d;
      c_wrdata_q   <= c_wrdata_d;
      status_q     <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rd_idx_d = rd_idx_q;

    unique case (state_q)
      IDLE, DONE: begin
        // A start edge beats a simultaneous clear_done.
        if (start_edge) begin
          if (bus.vec_len == '0) begin
            state_d = DONE;
          end else begin
            state_d  = RUN;
            len_d    = bus.vec_len;
            rd_idx_d = '0;
          end
        end else if (state_q == DONE && bus.ctrl[CTRL_CLEAR]) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Compared in ADDR_W+1 bits so a full 2**ADDR_W run ends on the last address.
        if (rd_idx_q == len_q - ONE) begin
          state_d = DRAIN;
        end else begin
          rd_idx_d = rd_idx_q + ONE;
        end
      end
      DRAIN: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Write stage trails the address stage by one cycle to absorb RAM read latency.
  always_comb begin
    pipe_valid_d = (state_q == RUN);
    pipe_idx_d   = rd_idx_q[ADDR_W-1:0];
    c_wren_d     = pipe_valid_q;
    c_addr_d     = c_addr_q;
    c_wrdata_d   = c_wrdata_q;
    if (pipe_valid_q) begin
      c_addr_d   = pipe_idx_q;
      c_wrdata_d = bus.a_rddata + bus.b_rddata;
    end

    status_d              = '0;
    status_d[STATUS_BUSY] = (state_q == RUN) || (state_q == DRAIN);
    status_d[STATUS_DONE] = (state_q == DONE);
  end

  assign bus.a_addr   = rd_idx_q[ADDR_W-1:0];
  assign bus.b_addr   = rd_idx_q[ADDR_W-1:0];
  assign bus.c_addr   = c_addr_q;
  assign bus.c_wrdata = c_wrdata_q;
  assign bus.c_wren   = c_wren_q;
  assign bus.status   = status_q;

endmodule
